// File: rtl/avalon_length_limiter_if.sv
// Avalon-ST interface shared by the length limiter's input and output streams.
// Carries one beat of DATA_WIDTH_IN_BYTES bytes plus packet framing.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_length_limiter.sv
// Caps packets at MAX_WORDS beats, truncating with a forced eop and dropping the tail.
// Reports each forwarded packet's byte length through a one-beat output register.
//
// state   | meaning
// IDLE    | waiting for a sop beat
// IN_PKT  | forwarding beats of the current packet
// DISCARD | packet was truncated; dropping beats up to its eop
module avalon_length_limiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_WORDS           = 64,
  parameter int LEN_WIDTH           = $clog2(MAX_WORDS*DATA_WIDTH_IN_BYTES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           msg_in,
  avalon_st_if.master          msg_out,
  output logic                 truncated_indi,
  output logic                 pkt_len_valid,
  output logic [LEN_WIDTH-1:0] pkt_len_bytes
);
  localparam int DW = 8*DATA_WIDTH_IN_BYTES;
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int CW = $clog2(MAX_WORDS+1);
  localparam logic [LEN_WIDTH-1:0] BYTES_PER_BEAT = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);

  typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;
  logic                 valid_q, sop_q, eop_q;
  logic [DW-1:0]        data_q;
  logic [EW-1:0]        empty_q;
  logic                 trunc_q, lenv_q;
  logic [LEN_WIDTH-1:0] len_q;

  logic                 in_rdy, accept, load, trunc, eop_fwd;
  logic [CW-1:0]        beat_cnt;
  logic [EW-1:0]        empty_fwd;
  logic [LEN_WIDTH-1:0] len_calc;

  // DISCARD never loads the output register, so it can always sink beats.
  assign in_rdy  = (state_q == DISCARD) ? 1'b1 : (!valid_q || msg_out.rdy);
  assign accept  = msg_in.valid && in_rdy;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    beat_cnt  = (state_q == IN_PKT) ? wcnt_q + CW'(1) : CW'(1);
    load      = accept && ((state_q == IDLE && msg_in.sop) || state_q == IN_PKT);
    trunc     = load && !msg_in.eop && (beat_cnt == CW'(MAX_WORDS));
    eop_fwd   = msg_in.eop || trunc;
    empty_fwd = trunc ? '0 : msg_in.empty;
    len_calc  = LEN_WIDTH'(beat_cnt) * BYTES_PER_BEAT - LEN_WIDTH'(empty_fwd);
    if (load) wcnt_d = beat_cnt;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (trunc)           state_d = DISCARD;
          else if (!msg_in.eop) state_d = IN_PKT;
        end
      end
      IN_PKT: begin
        if (load) begin
          if (msg_in.eop) state_d = IDLE;
          else if (trunc) state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (accept && msg_in.eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      trunc_q <= 1'b0;
      lenv_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      trunc_q <= load && trunc;
      lenv_q  <= load && eop_fwd;
      if (load && eop_fwd) len_q <= len_calc;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= msg_in.data;
        sop_q   <= msg_in.sop;
        eop_q   <= eop_fwd;
        empty_q <= empty_fwd;
      end else if (msg_out.rdy) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign msg_in.rdy     = in_rdy;
  assign msg_out.valid  = valid_q;
  assign msg_out.data   = data_q;
  assign msg_out.sop    = sop_q;
  assign msg_out.eop    = eop_q;
  assign msg_out.empty  = empty_q;
  assign truncated_indi = trunc_q;
  assign pkt_len_valid  = lenv_q;
  assign pkt_len_bytes  = len_q;
endmodule
